// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, frame constants and counter sizing for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;

    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: counts clocks within one UART bit and flags the last clock of each bit
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);

    localparam int W = cnt_width(CLKS_PER_BIT);

    logic [W-1:0] cnt;

    assign bit_end = en && (cnt == W'(CLKS_PER_BIT - 1));

    // restart on clr and at every bit boundary so the count never passes CLKS_PER_BIT-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || bit_end)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: pops bytes from a FIFO and sends them as 8N1 UART frames (UART_TX_PARITY_EN adds an even-parity bit)
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int IW = $clog2(DATA_BITS);

    state_t                 state;
    logic [DATA_BITS-1:0]   shreg;
    logic [IW-1:0]          idx;
    logic                   bit_end;
`ifdef UART_TX_PARITY_EN
    logic                   par;
`endif

    assign fifo_pop = (state == IDLE) && !fifo_empty && !rst;
    assign tx_done  = (state == STOP) && bit_end;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .clr    (fifo_pop),
        .en     (state != IDLE),
        .bit_end(bit_end)
    );

    // frame sequencer: latch on pop, then shift out start, data LSB-first, optional parity, stop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            shreg   <= '0;
            idx     <= '0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (fifo_pop) begin
                    state   <= START;
                    shreg   <= fifo_data;
                    tx      <= 1'b0;
                    tx_busy <= 1'b1;
                    idx     <= '0;
`ifdef UART_TX_PARITY_EN
                    par     <= ^fifo_data;
`endif
                end
                START: if (bit_end) begin
                    state <= DATA;
                    tx    <= shreg[0];
                    shreg <= shreg >> 1;
                end
                DATA: if (bit_end) begin
                    idx <= idx + 1'b1;
                    if (idx == IW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state <= PARITY;
                        tx    <= par;
`else
                        state <= STOP;
                        tx    <= 1'b1;
`endif
                    end else begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: if (bit_end) begin
                    state <= STOP;
                    tx    <= 1'b1;
                end
`endif
                STOP: if (bit_end) begin
                    state   <= IDLE;
                    tx_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: directed stimulus with a queue scoreboard decoding the serial line
module tb_uart_tx_fifo_drain;

    localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int F = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b0;
    logic [7:0] fifo_data = 8'hA5;
    logic       fifo_pop;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [7:0] exp_q[$];

    uart_tx_fifo_drain #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    // monitor: decodes each frame from the line and compares it against the next expected byte
    initial begin
        int pos;
        int k;
        logic [7:0] got;
        logic start_bit, stop_bit, par_bit, done_early;
        logic [7:0] e;
        pos = 0;
        got = '0;
        start_bit = 1'b1;
        stop_bit = 1'b0;
        par_bit = 1'b0;
        done_early = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_pop) pops++;
            if (rst) pos = 0;
            else if (pos != 0 || !tx) pos++;
            if (pos > 0) begin
                if (pos % CPB == 5) begin
                    k = pos / CPB;
                    if (k == 0) start_bit = tx;
                    else if (k <= 8) got[k-1] = tx;
                    else if (k == NB - 1) stop_bit = tx;
                    else par_bit = tx;
                end
                if (pos == F - 1) done_early = tx_done;
                if (pos == F) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame got %0h expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data", 32'(got), 32'(e));
                        check("start_bit", 32'(start_bit), 0);
                        check("stop_bit", 32'(stop_bit), 1);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", 32'(par_bit), 32'(^e));
`endif
                        check("done_in_last_stop_clk", {30'd0, done_early, tx_done}, 32'b01);
                        check("busy_during_stop", 32'(tx_busy), 1);
                    end
                    pos = 0;
                end
            end
        end
    end

    task automatic wait_pop(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fifo_pop && n < lim);
        check("pop_seen", 32'(fifo_pop), 1);
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_done && n < lim);
        check("done_seen", 32'(tx_done), 1);
    endtask

    task automatic finish_frame();
        int n;
        @(posedge clk);
        #1 fifo_empty = 1'b1;
        wait_done(3 * F, n);
        check("done_latency", n, F);
        @(negedge clk);
        check("idle_after_done", {30'd0, tx_busy, tx}, 32'b01);
    endtask

    task automatic send_one(input logic [7:0] b);
        int n;
        fifo_data = b;
        fifo_empty = 1'b0;
        wait_pop(50, n);
        exp_q.push_back(b);
        finish_frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        int extra;
        // reset held with data waiting: nothing may leave
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_outputs", {29'd0, fifo_pop, tx, tx_busy}, 32'b010);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wait_pop(50, n);
        check("first_pop_after_reset", n, 1);
        exp_q.push_back(8'hA5);
        finish_frame();

        // back-to-back 0x00 then 0xFF
        repeat (3) @(posedge clk);
        #1 fifo_data = 8'h00;
        fifo_empty = 1'b0;
        wait_pop(50, n);
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1 fifo_data = 8'hFF;
        exp_q.push_back(8'hFF);
        wait_pop(3 * F, n);
        check("pop_to_pop", n, F + 1);
        finish_frame();

        // FIFO inputs churn during a frame of 0x3C
        repeat (3) @(posedge clk);
        #1 fifo_data = 8'h3C;
        fifo_empty = 1'b0;
        wait_pop(50, n);
        exp_q.push_back(8'h3C);
        extra = 0;
        for (int i = 1; i <= 95; i++) begin
            @(posedge clk);
            #1 fifo_empty = i[0];
            fifo_data = 8'(i * 37);
            @(negedge clk);
            if (fifo_pop) extra++;
        end
        fifo_empty = 1'b1;
        wait_done(3 * F, n);
        check("no_pop_mid_frame", extra, 0);

        // reset during data bit 3 of 0x55, then a fresh frame
        repeat (3) @(posedge clk);
        #1 fifo_data = 8'h55;
        fifo_empty = 1'b0;
        wait_pop(50, n);
        exp_q.push_back(8'h55);
        repeat (45) @(negedge clk);
        check("tx_bit3_before_reset", 32'(tx), 0);
        #2 rst = 1'b1;
        #1 check("async_reset_outputs", {29'd0, fifo_pop, tx, tx_busy}, 32'b010);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_pop(50, n);
        check("pop_after_midframe_reset", n, 1);
        finish_frame();

        // parity-relevant bytes (odd and even number of ones)
        repeat (3) @(posedge clk);
        #1 send_one(8'h07);
        repeat (3) @(posedge clk);
        #1 send_one(8'h03);

        repeat (5) @(negedge clk);
        check("all_frames_seen", exp_q.size(), 0);
        check("total_pops", pops, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
